// File: rtl/alu_seq.sv
// alu_seq: sequences commands into an external combinational ALU and queues
// the results in a small response FIFO.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready, i_cmd_a, i_cmd_b, i_cmd_op   command handshake
//   o_alu_a, o_alu_b, o_alu_opcode, o_alu_ena, i_alu_result  external ALU
//   o_rsp_valid/i_rsp_ready, o_rsp_data, o_rsp_err         response FIFO head
//   o_op_count          completed response handshakes (wrapping)
module alu_seq #(
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [7:0]  i_cmd_a,
    input  logic [7:0]  i_cmd_b,
    input  logic [2:0]  i_cmd_op,
    output logic [7:0]  o_alu_a,
    output logic [7:0]  o_alu_b,
    output logic [2:0]  o_alu_opcode,
    output logic        o_alu_ena,
    input  logic [15:0] i_alu_result,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [15:0] o_rsp_data,
    output logic        o_rsp_err,
    output logic [15:0] o_op_count
);

    localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    state_t             r_state;
    logic [7:0]         r_alu_a;
    logic [7:0]         r_alu_b;
    logic [2:0]         r_alu_opcode;
    logic               r_alu_ena;
    logic [15:0]        r_data_mem [RSP_DEPTH];
    logic               r_err_mem  [RSP_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [15:0]        r_op_count;

    logic               w_accept;
    logic               w_pop;
    logic               w_push;
    logic               w_div_zero;

    // Ready depends only on registered state (and reset), never on cmd_valid.
    assign o_cmd_ready = !i_rst && (r_state == ST_IDLE) && (r_count < CNT_W'(RSP_DEPTH));
    assign o_rsp_valid = (r_count != '0);

    assign w_accept   = i_cmd_valid && o_cmd_ready;
    assign w_pop      = o_rsp_valid && i_rsp_ready;
    assign w_push     = (r_state == ST_EXEC);
    assign w_div_zero = ((r_alu_opcode == 3'b011) || (r_alu_opcode == 3'b100)) && (r_alu_b == 8'h00);

    assign o_alu_a      = r_alu_a;
    assign o_alu_b      = r_alu_b;
    assign o_alu_opcode = r_alu_opcode;
    assign o_alu_ena    = r_alu_ena;
    assign o_rsp_data   = r_data_mem[r_rd_ptr];
    assign o_rsp_err    = r_err_mem[r_rd_ptr];
    assign o_op_count   = r_op_count;

    // Control FSM, operand registers and response FIFO.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_opcode <= '0;
            r_alu_ena    <= 1'b0;
            r_data_mem   <= '{default: '0};
            r_err_mem    <= '{default: 1'b0};
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_op_count   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_alu_a      <= i_cmd_a;
                        r_alu_b      <= i_cmd_b;
                        r_alu_opcode <= i_cmd_op;
                        r_alu_ena    <= 1'b1;
                        r_state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Accept was gated on free space, so this push never overflows.
                    r_data_mem[r_wr_ptr] <= i_alu_result;
                    r_err_mem[r_wr_ptr]  <= w_div_zero;
                    r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
                    r_alu_ena            <= 1'b0;
                    r_state              <= ST_IDLE;
                end
                default: begin
                    r_alu_ena <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase

            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
                r_op_count <= r_op_count + 16'd1;
            end

            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq. Provides a behavioural ALU,
// keeps a queue-based scoreboard of expected responses with their earliest
// visible cycle, and runs directed scenarios plus randomized traffic.
module tb_alu_seq;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [2:0]  cmd_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_opcode;
    logic        alu_ena;
    logic [15:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [15:0] op_count;

    always #5 clk = ~clk;

    alu_seq #(.RSP_DEPTH(DEPTH)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_a      (cmd_a),
        .i_cmd_b      (cmd_b),
        .i_cmd_op     (cmd_op),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_opcode (alu_opcode),
        .o_alu_ena    (alu_ena),
        .i_alu_result (alu_result),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_data   (rsp_data),
        .o_rsp_err    (rsp_err),
        .o_op_count   (op_count)
    );

    function automatic logic [15:0] ref_alu(logic [7:0] a, logic [7:0] b, logic [2:0] op);
        case (op)
            3'd0:    return 16'(a) + 16'(b);
            3'd1:    return 16'(a) - 16'(b);
            3'd2:    return 16'(a) * 16'(b);
            3'd3:    return (b == 8'd0) ? 16'd0 : 16'(a / b);
            3'd4:    return (b == 8'd0) ? 16'd0 : 16'(a % b);
            3'd5:    return 16'(a == b);
            3'd6:    return 16'(a > b);
            default: return 16'(a < b);
        endcase
    endfunction

    function automatic logic ref_err(logic [7:0] b, logic [2:0] op);
        return ((op == 3'd3) || (op == 3'd4)) && (b == 8'd0);
    endfunction

    // External ALU; a poison value outside EXEC exposes mistimed pushes.
    always_comb alu_result = alu_ena ? ref_alu(alu_a, alu_b, alu_opcode) : 16'hDEAD;

    typedef struct {
        logic [15:0] d;
        logic        e;
        int          avail;
    } exp_t;

    exp_t        exp_q[$];
    logic [16:0] got_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          edge_n   = 0;
    bit          m_busy   = 1'b0;
    bit          last_acc = 1'b0;
    logic [15:0] m_opcnt  = 16'd0;
    logic [7:0]  m_a      = 8'd0;
    logic [7:0]  m_b      = 8'd0;
    logic [2:0]  m_op     = 3'd0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: check outputs against the model, then advance model and DUT.
    task automatic tick();
        bit exp_ready;
        bit exp_valid;
        bit acc;
        bit pop;
        #1;
        exp_ready = !rst && !m_busy && (exp_q.size() < DEPTH);
        exp_valid = (exp_q.size() > 0) && (exp_q[0].avail <= edge_n);
        chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        chk("alu_ena", 32'(alu_ena), 32'(m_busy));
        chk("op_count", 32'(op_count), 32'(m_opcnt));
        chk("alu_a", 32'(alu_a), 32'(m_a));
        chk("alu_b", 32'(alu_b), 32'(m_b));
        chk("alu_opcode", 32'(alu_opcode), 32'(m_op));
        pop = exp_valid && rsp_ready && !rst;
        if (pop) begin
            chk("rsp_data", 32'(rsp_data), 32'(exp_q[0].d));
            chk("rsp_err", 32'(rsp_err), 32'(exp_q[0].e));
            got_q.push_back({rsp_err, rsp_data});
            void'(exp_q.pop_front());
            m_opcnt++;
        end
        acc = cmd_valid && exp_ready;
        @(posedge clk);
        edge_n++;
        if (rst) begin
            exp_q.delete();
            m_busy   = 1'b0;
            last_acc = 1'b0;
            m_opcnt  = 16'd0;
            m_a      = 8'd0;
            m_b      = 8'd0;
            m_op     = 3'd0;
        end else begin
            if (acc) begin
                exp_q.push_back('{ref_alu(cmd_a, cmd_b, cmd_op), ref_err(cmd_b, cmd_op), edge_n + 1});
                m_a  = cmd_a;
                m_b  = cmd_b;
                m_op = cmd_op;
            end
            m_busy   = acc;
            last_acc = acc;
        end
        @(negedge clk);
    endtask

    task automatic send(logic [7:0] a, logic [7:0] b, logic [2:0] op);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (last_acc) break;
        end
        chk("send_accept", 32'(last_acc), 32'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = 8'd0;
        cmd_b     = 8'd0;
        cmd_op    = 3'd0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_alu_ena", 32'(alu_ena), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        tick();
        rst = 1'b0;

        // Add with latency check: visible exactly two edges after accept
        rsp_ready = 1'b1;
        got_q.delete();
        send(8'd200, 8'd100, 3'd0);
        chk("add_valid_early", 32'(rsp_valid), 32'd0);
        tick();
        chk("add_valid", 32'(rsp_valid), 32'd1);
        chk("add_data", 32'(rsp_data), 32'h012C);
        chk("add_err", 32'(rsp_err), 32'd0);
        tick();
        chk("add_op_count", 32'(op_count), 32'd1);

        // Divide / modulo by zero, then a legal divide
        got_q.delete();
        send(8'd7, 8'd0, 3'd3);
        send(8'd7, 8'd0, 3'd4);
        send(8'd7, 8'd2, 3'd3);
        drain();
        chk("dz_count", 32'(got_q.size()), 32'd3);
        chk("dz_div", 32'(got_q[0]), 32'h10000);
        chk("dz_mod", 32'(got_q[1]), 32'h10000);
        chk("dz_ok", 32'(got_q[2]), 32'h00003);

        // Simultaneous push and pop with one entry resident
        rsp_ready = 1'b0;
        got_q.delete();
        send(8'd3, 8'd4, 3'd0);
        tick();
        send(8'd10, 8'd4, 3'd1);
        rsp_ready = 1'b1;
        tick();
        chk("pp_valid", 32'(rsp_valid), 32'd1);
        chk("pp_data", 32'(rsp_data), 32'h0006);
        drain();
        chk("pp_first", 32'(got_q[0]), 32'h00007);
        chk("pp_second", 32'(got_q[1]), 32'h00006);

        // Backpressure: full FIFO blocks a third command until a pop
        rsp_ready = 1'b0;
        got_q.delete();
        send(8'd15, 8'd17, 3'd2);
        send(8'd255, 8'd255, 3'd2);
        cmd_valid = 1'b1;
        cmd_a     = 8'd2;
        cmd_b     = 8'd3;
        cmd_op    = 3'd2;
        repeat (4) tick();
        chk("bp_ready_low", 32'(cmd_ready), 32'd0);
        chk("bp_head", 32'(rsp_data), 32'h00FF);
        rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (last_acc) break;
        end
        chk("bp_accept", 32'(last_acc), 32'd1);
        drain();
        chk("bp_first", 32'(got_q[0]), 32'h000FF);
        chk("bp_second", 32'(got_q[1]), 32'h0FE01);
        chk("bp_third", 32'(got_q[2]), 32'h00006);

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 600; i++) begin
            cmd_valid = ($urandom_range(0, 9) < 7);
            cmd_a     = 8'($urandom);
            cmd_b     = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            cmd_op    = 3'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        drain();

        // Reset during EXEC discards the in-flight op and has priority
        rsp_ready = 1'b1;
        send(8'd1, 8'd1, 3'd0);
        rst       = 1'b1;
        cmd_valid = 1'b1;
        tick();
        rst       = 1'b0;
        cmd_valid = 1'b0;
        repeat (6) tick();
        chk("rst_exec_valid", 32'(rsp_valid), 32'd0);
        chk("rst_exec_op_count", 32'(op_count), 32'd0);

        // Counter wrap: preload near the top, then complete compare ops
        force dut.r_op_count = 16'hFFFC;
        m_opcnt = 16'hFFFC;
        tick();
        release dut.r_op_count;
        got_q.delete();
        rsp_ready = 1'b1;
        repeat (4) send(8'd5, 8'd5, 3'd5);
        drain();
        tick();
        chk("wrap_op_count", 32'(op_count), 32'd0);
        chk("wrap_last_rsp", 32'(got_q[3]), 32'h00001);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
